// File: rtl/alu_bus_master_pkg.sv
// Shared definitions for the ALU bus master: slave register map, the
// default result-RAM window base, the sequencer state encoding and a helper
// for the result-RAM address.
package alu_bus_master_pkg;

    // ALU slave register map
    localparam logic [7:0] ADDR_OPA  = 8'h00;
    localparam logic [7:0] ADDR_OPB  = 8'h01;
    localparam logic [7:0] ADDR_OP   = 8'h02;
    localparam logic [7:0] ADDR_RES  = 8'h03;
    localparam logic [7:0] ADDR_STAT = 8'h04;
    localparam logic [7:0] ADDR_GO   = 8'h05;

    // Default base of the result RAM window
    localparam logic [7:0] RAM_BASE_DEFAULT = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WR_A      = 4'd1,
        ST_WR_B      = 4'd2,
        ST_WR_OP     = 4'd3,
        ST_WR_GO     = 4'd4,
        ST_RD_STAT   = 4'd5,
        ST_STAT_WAIT = 4'd6,
        ST_RD_RES    = 4'd7,
        ST_RES_WAIT  = 4'd8,
        ST_WR_RAM    = 4'd9,
        ST_RESP      = 4'd10
    } state_e;

    // Result RAM address; the sum wraps within the 8-bit bus address space.
    function automatic logic [7:0] ram_addr(input logic [7:0] base, input logic [4:0] idx);
        return base + {3'b000, idx};
    endfunction

endpackage

// File: rtl/alu_bus_master.sv
// ALU bus master: takes one command, programs the ALU slave over a
// request/grant bus, polls its status register (bounded by POLL_MAX), reads
// the result, stores it into the result RAM window and reports completion.
// All bus and response outputs are registered, computed from the next state.
module alu_bus_master
    import alu_bus_master_pkg::*;
#(
    parameter logic [7:0]  RAM_BASE = RAM_BASE_DEFAULT,
    parameter int unsigned POLL_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_opa,
    input  logic [31:0] cmd_opb,
    input  logic [3:0]  cmd_op,
    input  logic [4:0]  cmd_idx,
    output logic        M_req,
    output logic        M_wr,
    output logic [7:0]  M_addr,
    output logic [31:0] M_dout,
    input  logic        M_grant,
    input  logic [31:0] M_din,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam int unsigned   PW         = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0] POLL_LIMIT = PW'(POLL_MAX);

    state_e        state_q, state_d;
    logic [31:0]   opa_q, opa_d;
    logic [31:0]   opb_q, opb_d;
    logic [3:0]    op_q, op_d;
    logic [4:0]    idx_q, idx_d;
    logic [31:0]   result_q, result_d;
    logic          err_q, err_d;
    // Number of status reads issued for the current command
    logic [PW-1:0] poll_q, poll_d;

    logic          req_q, req_d;
    logic          wr_q, wr_d;
    logic [7:0]    addr_q, addr_d;
    logic [31:0]   dout_q, dout_d;
    logic          ready_q, ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    logic          beat_done_s;

    assign beat_done_s = req_q & M_grant;

    // Sequencer next state and command/result bookkeeping
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        op_d     = op_q;
        idx_d    = idx_q;
        result_d = result_q;
        err_d    = err_q;
        poll_d   = poll_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    opa_d    = cmd_opa;
                    opb_d    = cmd_opb;
                    op_d     = cmd_op;
                    idx_d    = cmd_idx;
                    result_d = 32'h0000_0000;
                    err_d    = 1'b0;
                    poll_d   = '0;
                    state_d  = ST_WR_A;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WR_A:   state_d = beat_done_s ? ST_WR_B    : ST_WR_A;
            ST_WR_B:   state_d = beat_done_s ? ST_WR_OP   : ST_WR_B;
            ST_WR_OP:  state_d = beat_done_s ? ST_WR_GO   : ST_WR_OP;
            ST_WR_GO:  state_d = beat_done_s ? ST_RD_STAT : ST_WR_GO;
            ST_RD_STAT: begin
                if (beat_done_s) begin
                    poll_d  = poll_q + {{(PW-1){1'b0}}, 1'b1};
                    state_d = ST_STAT_WAIT;
                end else begin
                    state_d = ST_RD_STAT;
                end
            end
            ST_STAT_WAIT: begin
                if (M_din[0]) begin
                    state_d = ST_RD_RES;
                end else if (poll_q < POLL_LIMIT) begin
                    state_d = ST_RD_STAT;
                end else begin
                    // Slave never reported done: give up without result/RAM beats
                    err_d    = 1'b1;
                    result_d = 32'h0000_0000;
                    state_d  = ST_RESP;
                end
            end
            ST_RD_RES: state_d = beat_done_s ? ST_RES_WAIT : ST_RD_RES;
            ST_RES_WAIT: begin
                result_d = M_din;
                state_d  = ST_WR_RAM;
            end
            ST_WR_RAM: state_d = beat_done_s ? ST_RESP : ST_WR_RAM;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Bus and response output values for the state being entered
    always_comb begin
        req_d  = 1'b0;
        wr_d   = 1'b0;
        addr_d = 8'h00;
        dout_d = 32'h0000_0000;
        case (state_d)
            ST_WR_A: begin
                req_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_OPA; dout_d = opa_d;
            end
            ST_WR_B: begin
                req_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_OPB; dout_d = opb_d;
            end
            ST_WR_OP: begin
                req_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_OP; dout_d = {28'h000_0000, op_d};
            end
            ST_WR_GO: begin
                req_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_GO; dout_d = 32'h0000_0001;
            end
            ST_RD_STAT: begin
                req_d = 1'b1; addr_d = ADDR_STAT;
            end
            ST_RD_RES: begin
                req_d = 1'b1; addr_d = ADDR_RES;
            end
            ST_WR_RAM: begin
                req_d = 1'b1; wr_d = 1'b1; addr_d = ram_addr(RAM_BASE, idx_d); dout_d = result_d;
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
        ready_d     = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        rsp_data_d  = rsp_valid_d ? result_d : 32'h0000_0000;
        rsp_err_d   = rsp_valid_d ? err_d : 1'b0;
    end

    // State, bookkeeping and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            opa_q       <= 32'h0000_0000;
            opb_q       <= 32'h0000_0000;
            op_q        <= 4'h0;
            idx_q       <= 5'd0;
            result_q    <= 32'h0000_0000;
            err_q       <= 1'b0;
            poll_q      <= '0;
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 8'h00;
            dout_q      <= 32'h0000_0000;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            err_q       <= err_d;
            poll_q      <= poll_d;
            req_q       <= req_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = ready_q;
    assign M_req     = req_q;
    assign M_wr      = wr_q;
    assign M_addr    = addr_q;
    assign M_dout    = dout_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_bus_master.sv
// Self-checking bench for alu_bus_master. The bench plays the bus slave
// (grant, status, result), logs every completed beat and compares the log,
// response and latency against an expected transaction list built from the
// command and the slave behaviour.
module tb_alu_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [31:0] cmd_opa, cmd_opb;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_idx;
    logic        M_grant;
    logic [31:0] M_din;

    logic        cmd_ready, M_req, M_wr, rsp_valid, rsp_err;
    logic [7:0]  M_addr;
    logic [31:0] M_dout, rsp_data;

    logic        cmd_ready_b, M_req_b, M_wr_b, rsp_valid_b, rsp_err_b;
    logic [7:0]  M_addr_b;
    logic [31:0] M_dout_b, rsp_data_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_wr[$], got_addr[$], got_dout[$], got_addr_b[$];
    logic [31:0] exp_wr[$], exp_addr[$], exp_dout[$], exp_addr_b[$];

    alu_bus_master dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
        .M_req(M_req), .M_wr(M_wr), .M_addr(M_addr), .M_dout(M_dout),
        .M_grant(M_grant), .M_din(M_din),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    alu_bus_master #(.RAM_BASE(8'hF0)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
        .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
        .M_req(M_req_b), .M_wr(M_wr_b), .M_addr(M_addr_b), .M_dout(M_dout_b),
        .M_grant(M_grant), .M_din(M_din),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic wr, input logic [7:0] addr, input logic [31:0] dout,
                            input logic [7:0] addr_b);
        exp_wr.push_back({31'd0, wr});
        exp_addr.push_back({24'd0, addr});
        exp_dout.push_back(wr ? dout : 32'h0);
        exp_addr_b.push_back({24'd0, addr_b});
    endtask

    // One full command: zeros = status reads returning 0 before one returns 1
    // (>= 16 means the slave never finishes); stall_beat/stall_len withhold
    // the grant on one beat.
    task automatic run_cmd(input logic [31:0] opa, input logic [31:0] opb, input logic [3:0] op,
                           input logic [4:0] idx, input int zeros, input logic [31:0] res,
                           input int stall_beat, input int stall_len, input string name);
        int          k, beat, stalled, poll_i, npolls, lat;
        bit          done, tmo, rd_stat, rd_res;
        logic [7:0]  hold_addr;
        logic [31:0] hold_dout, rnd;
        logic [7:0]  ram_a, ram_b;

        // Expected transaction list
        exp_wr.delete(); exp_addr.delete(); exp_dout.delete(); exp_addr_b.delete();
        got_wr.delete(); got_addr.delete(); got_dout.delete(); got_addr_b.delete();
        tmo    = (zeros >= 16);
        npolls = tmo ? 16 : zeros + 1;
        ram_a  = 8'h20 + {3'b000, idx};
        ram_b  = 8'hF0 + {3'b000, idx};
        push_exp(1'b1, 8'h00, opa, 8'h00);
        push_exp(1'b1, 8'h01, opb, 8'h01);
        push_exp(1'b1, 8'h02, {28'h0, op}, 8'h02);
        push_exp(1'b1, 8'h05, 32'h1, 8'h05);
        for (int i = 0; i < npolls; i++) push_exp(1'b0, 8'h04, 32'h0, 8'h04);
        if (!tmo) begin
            push_exp(1'b0, 8'h03, 32'h0, 8'h03);
            push_exp(1'b1, ram_a, res, ram_b);
        end
        lat = 4 + 2 * npolls + (tmo ? 1 : 4) + ((stall_beat >= 0) ? stall_len : 0);

        // Accept the command
        M_grant   = 1'b1;
        cmd_valid = 1'b1;
        cmd_opa = opa; cmd_opb = opb; cmd_op = op; cmd_idx = idx;
        check({name, " ready_idle"}, {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        cmd_opa = $urandom; cmd_opb = $urandom; cmd_op = 4'($urandom); cmd_idx = 5'($urandom);

        k = 1; beat = 0; stalled = 0; poll_i = 0; done = 1'b0;
        hold_addr = 8'h00; hold_dout = 32'h0;
        while (!done && k <= 300) begin
            if (rsp_valid) begin
                done = 1'b1;
                check({name, " latency"}, k, lat);
                check({name, " rsp_data"}, rsp_data, tmo ? 32'h0 : res);
                check({name, " rsp_err"}, {31'd0, rsp_err}, {31'd0, tmo});
                check({name, " req_in_resp"}, {31'd0, M_req}, 32'd0);
            end else begin
                // Commands offered while busy must be ignored
                cmd_valid = (k >= 2 && k <= 5);
                if (k == 3) check({name, " ready_busy"}, {31'd0, cmd_ready}, 32'd0);
                if (M_req && beat == stall_beat && stalled < stall_len) begin
                    if (stalled == 0) begin
                        hold_addr = M_addr;
                        hold_dout = M_dout;
                    end else begin
                        check({name, " stall_addr"}, {24'd0, M_addr}, {24'd0, hold_addr});
                        check({name, " stall_dout"}, M_dout, hold_dout);
                    end
                    M_grant = 1'b0;
                    stalled++;
                end else begin
                    M_grant = 1'b1;
                end
                rd_stat = 1'b0;
                rd_res  = 1'b0;
                if (M_req && M_grant) begin
                    got_wr.push_back({31'd0, M_wr});
                    got_addr.push_back({24'd0, M_addr});
                    got_dout.push_back(M_wr ? M_dout : 32'h0);
                    got_addr_b.push_back({24'd0, M_addr_b});
                    beat++;
                    rd_stat = !M_wr && (M_addr == 8'h04);
                    rd_res  = !M_wr && (M_addr == 8'h03);
                end
                step();
                k++;
                rnd = $urandom;
                if (rd_stat) begin
                    M_din = {rnd[31:1], (poll_i >= zeros) ? 1'b1 : 1'b0};
                    poll_i++;
                end else if (rd_res) begin
                    M_din = res;
                end else begin
                    M_din = rnd;
                end
            end
        end
        cmd_valid = 1'b0;
        M_grant   = 1'b1;
        if (!done) check({name, " rsp_timeout"}, 32'd0, 32'd1);

        check({name, " beat_count"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            check($sformatf("%s beat%0d_wr", name, i), got_wr[i], exp_wr[i]);
            check($sformatf("%s beat%0d_addr", name, i), got_addr[i], exp_addr[i]);
            check($sformatf("%s beat%0d_dout", name, i), got_dout[i], exp_dout[i]);
            check($sformatf("%s beat%0d_addr_b", name, i), got_addr_b[i], exp_addr_b[i]);
        end

        step();
        check({name, " rsp_one_cycle"}, {31'd0, rsp_valid}, 32'd0);
        check({name, " ready_after"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1; cmd_valid = 1'b0; M_grant = 1'b0; M_din = 32'h0;
        cmd_opa = 32'h0; cmd_opb = 32'h0; cmd_op = 4'h0; cmd_idx = 5'd0;

        // Reset state
        step(); step();
        check("rst M_req", {31'd0, M_req}, 32'd0);
        check("rst M_wr", {31'd0, M_wr}, 32'd0);
        check("rst M_addr", {24'd0, M_addr}, 32'd0);
        check("rst M_dout", M_dout, 32'd0);
        check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst rsp_data", rsp_data, 32'd0);
        check("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
        reset = 1'b0;
        step();

        // Directed scenarios
        run_cmd(32'h0, 32'hFFFF_0000, 4'hA, 5'd0, 0, 32'h0000_FFFF, -1, 0, "basic");
        run_cmd(32'h0, 32'hFFFF_0000, 4'hA, 5'd0, 3, 32'h0000_FFFF, -1, 0, "poll3");
        run_cmd(32'h1234_5678, 32'h9ABC_DEF0, 4'h3, 5'd7, 16, 32'hDEAD_BEEF, -1, 0, "timeout");
        run_cmd(32'h1111_2222, 32'h3333_4444, 4'h5, 5'd2, 0, 32'h5555_6666, 1, 5, "stall_wrb");
        run_cmd(32'hA5A5_A5A5, 32'h5A5A_5A5A, 4'hF, 5'd31, 0, 32'hCAFE_F00D, -1, 0, "idx31");

        // Reset while the result read is on the bus
        M_grant = 1'b1; M_din = 32'h1;
        cmd_valid = 1'b1; cmd_opa = 32'h7; cmd_opb = 32'h8; cmd_op = 4'h1; cmd_idx = 5'd4;
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (!(M_req && M_addr == 8'h03) && n < 50) begin
            step();
            n++;
        end
        check("mid_reset reached_rd_res", {31'd0, (M_req && M_addr == 8'h03)}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_reset M_req", {31'd0, M_req}, 32'd0);
        check("mid_reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_reset M_addr", {24'd0, M_addr}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_reset no_rsp", {31'd0, rsp_valid}, 32'd0);
            check("mid_reset idle_req", {31'd0, M_req}, 32'd0);
        end
        run_cmd(32'h0BAD_F00D, 32'h0000_0042, 4'h9, 5'd9, 1, 32'h0102_0304, -1, 0, "after_reset");

        // Randomized commands
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb, rr;
            int z, sb, sl;
            ra = $urandom; rb = $urandom; rr = $urandom;
            z  = $urandom_range(0, 4);
            sb = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 6) : -1;
            sl = $urandom_range(1, 4);
            run_cmd(ra, rb, 4'($urandom), 5'($urandom), z, rr, sb, sl, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
